// File: rtl/data_bus_arbiter.sv
// ----------------------------------------------------------------------------
// data_bus_arbiter
//
// Responder side of the MiniRISC data-memory bus request/grant handshake.
// Masters (0 = CPU core, 1 = stack unit, 2 = DMA, ...) raise mst_req and hold
// address, write data and direction until they see their one-cycle grant.
// The arbiter picks one owner, routes that owner's slice to the data memory,
// inserts WAIT_STATES extra memory cycles and pulses the owner's grant in the
// completing cycle. Read data is returned on mst_din in the grant cycle.
//
// Parameters
//   N_MST        number of masters, 2..8
//   WAIT_STATES  extra memory cycles per access, 0..15
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst       in   synchronous reset, active-low; forces every output to 0
//   mst_req   in   per-master request, held until granted
//   mst_wr    in   per-master direction, 1 = write
//   mst_addr  in   per-master address, master i on bits [8i+7:8i]
//   mst_dout  in   per-master write data, same packing as mst_addr
//   mst_gnt   out  one-hot grant pulse marking the completing cycle
//   mst_din   out  read data, mem_din in a read grant cycle, else 0
//   mem_addr  out  memory address (owner's slice during an access)
//   mem_wr    out  memory write strobe, only in a write grant cycle
//   mem_rd    out  memory read enable during a read access
//   mem_dout  out  memory write data (owner's slice during an access)
//   mem_din   in   memory read data, asynchronous read
//   busy      out  high while an access is in progress
//
// Configuration
//   DBUS_FIXED_PRIO_EN  when defined, the lowest requesting index always wins;
//                       rr_last is still tracked but ignored. Default build
//                       (undefined) uses round robin after the last grantee.
// ----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int N_MST       = 3,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MST-1:0]     mst_req,
    input  logic [N_MST-1:0]     mst_wr,
    input  logic [8*N_MST-1:0]   mst_addr,
    input  logic [8*N_MST-1:0]   mst_dout,
    output logic [N_MST-1:0]     mst_gnt,
    output logic [7:0]           mst_din,
    output logic [7:0]           mem_addr,
    output logic                 mem_wr,
    output logic                 mem_rd,
    output logic [7:0]           mem_dout,
    input  logic [7:0]           mem_din,
    output logic                 busy
);

    localparam int              IDX_W     = $clog2(N_MST);
    localparam int              IW1       = IDX_W + 1;
    localparam logic [IW1-1:0]  N_W       = IW1'(N_MST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MST - 1);
    localparam logic [3:0]      WS_LOAD   = 4'(WAIT_STATES);
    localparam bit              ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_last;
    logic [3:0]       wait_cnt;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    // Owner selection from the live request vector.
`ifdef DBUS_FIXED_PRIO_EN
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        // Scan downward so the lowest requesting index is the last writer.
        for (int i = N_MST - 1; i >= 0; i--) begin
            if (mst_req[IDX_W'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IW1-1:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_sum = '0;
        cand     = '0;
        // Candidate i is (rr_last + 1 + i) mod N_MST; the sum never reaches
        // 2*N_MST, so one conditional subtract is a full modulo.
        for (int i = 0; i < N_MST; i++) begin
            cand_sum = {1'b0, rr_last} + IW1'(i + 1);
            if (cand_sum >= N_W) begin
                cand_sum = cand_sum - N_W;
            end
            cand = cand_sum[IDX_W-1:0];
            if (!pick_vld && mst_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end
`endif

    // Which master drives the bus this cycle, whether an access is live and
    // whether this is its completing (grant) cycle. A zero-wait access is
    // started and completed in the IDLE cycle itself. In ACCESS the owner's
    // withdrawn request aborts the access at once, so nothing is driven.
    logic [IDX_W-1:0] cur_idx;
    logic             access_live;
    logic             grant_now;

    always_comb begin
        cur_idx     = owner;
        access_live = 1'b0;
        grant_now   = 1'b0;
        if (state == S_IDLE) begin
            if (ZERO_WAIT && pick_vld) begin
                cur_idx     = pick_idx;
                access_live = 1'b1;
                grant_now   = 1'b1;
            end
        end else if (mst_req[owner]) begin
            access_live = 1'b1;
            grant_now   = (wait_cnt == 4'd0);
        end
        if (!rst) begin
            access_live = 1'b0;
            grant_now   = 1'b0;
        end
    end

    logic [7:0] sel_addr;
    logic [7:0] sel_dout;
    logic       sel_wr;

    // Slices are sampled live every cycle; masters hold them stable.
    assign sel_addr = mst_addr[{cur_idx, 3'b000} +: 8];
    assign sel_dout = mst_dout[{cur_idx, 3'b000} +: 8];
    assign sel_wr   = mst_wr[cur_idx];

    always_comb begin
        mst_gnt  = '0;
        mst_din  = 8'h00;
        mem_addr = 8'h00;
        mem_dout = 8'h00;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        busy     = 1'b0;
        if (access_live) begin
            mem_addr = sel_addr;
            mem_dout = sel_dout;
            mem_rd   = ~sel_wr;
            busy     = 1'b1;
            if (grant_now) begin
                mst_gnt[cur_idx] = 1'b1;
                mem_wr           = sel_wr;
                if (!sel_wr) begin
                    mst_din = mem_din;
                end
            end
        end
    end

    // ACCESS lasts WAIT_STATES+1 cycles (wait_cnt WAIT_STATES down to 0);
    // the IDLE selection cycle itself drives nothing when WAIT_STATES > 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            wait_cnt <= 4'd0;
            rr_last  <= LAST_IDX;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        if (ZERO_WAIT) begin
                            rr_last <= pick_idx;
                        end else begin
                            wait_cnt <= WS_LOAD;
                            state    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!mst_req[owner]) begin
                        // Abort: no grant, rr_last keeps its value.
                        state    <= S_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == 4'd0) begin
                        state   <= S_IDLE;
                        rr_last <= owner;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic sb_on;
    logic mem_clr;

    // Instance a: WAIT_STATES = 0
    logic [2:0]  a_req, a_wr, a_gnt;
    logic [23:0] a_addr, a_dout;
    logic [7:0]  a_din, a_maddr, a_mdout, a_mdin;
    logic        a_mwr, a_mrd, a_busy;
    // Instance b: WAIT_STATES = 2
    logic [2:0]  b_req, b_wr, b_gnt;
    logic [23:0] b_addr, b_dout;
    logic [7:0]  b_din, b_maddr, b_mdout, b_mdin;
    logic        b_mwr, b_mrd, b_busy;

    data_bus_arbiter #(.N_MST(3), .WAIT_STATES(0)) u_a (
        .clk(clk), .rst(rst), .mst_req(a_req), .mst_wr(a_wr),
        .mst_addr(a_addr), .mst_dout(a_dout), .mst_gnt(a_gnt), .mst_din(a_din),
        .mem_addr(a_maddr), .mem_wr(a_mwr), .mem_rd(a_mrd), .mem_dout(a_mdout),
        .mem_din(a_mdin), .busy(a_busy)
    );

    data_bus_arbiter #(.N_MST(3), .WAIT_STATES(2)) u_b (
        .clk(clk), .rst(rst), .mst_req(b_req), .mst_wr(b_wr),
        .mst_addr(b_addr), .mst_dout(b_dout), .mst_gnt(b_gnt), .mst_din(b_din),
        .mem_addr(b_maddr), .mem_wr(b_mwr), .mem_rd(b_mrd), .mem_dout(b_mdout),
        .mem_din(b_mdin), .busy(b_busy)
    );

    // Data memory models, asynchronous read, write on the rising edge.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
            mem_b[8'h10] <= 8'hA5;
            mem_b[8'h41] <= 8'h5A;
            mem_b[8'h51] <= 8'h3C;
        end else begin
            if (a_mwr) mem_a[a_maddr] <= a_mdout;
            if (b_mwr) mem_b[b_maddr] <= b_mdout;
        end
    end

    assign a_mdin = mem_a[a_maddr];
    assign b_mdin = mem_b[b_maddr];

    // Scoreboard: one expected transaction per grant.
    typedef struct packed {
        logic [2:0] gnt;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] dout;
        logic [7:0] din;
    } txn_t;

    txn_t qa[$];
    txn_t qb[$];
    txn_t a_got, a_exp, b_got, b_exp;

    function automatic txn_t mk(input logic [2:0] g, input logic [7:0] ad,
                                input logic w, input logic [7:0] dt, input logic [7:0] di);
        txn_t t;
        t.gnt  = g;
        t.addr = ad;
        t.wr   = w;
        t.dout = dt;
        t.din  = di;
        return t;
    endfunction

    always @(negedge clk) begin
        if (sb_on) begin
            a_got = mk(a_gnt, a_maddr, a_mwr, a_mdout, a_din);
            checks++;
            if (a_gnt !== 3'b000) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL sb_a unexpected grant got gnt=%b addr=%h want no grant", a_gnt, a_maddr);
                end else begin
                    a_exp = qa.pop_front();
                    if (a_got !== a_exp) begin
                        errors++;
                        $display("FAIL sb_a txn got=%h want=%h (gnt,addr,wr,dout,din)", a_got, a_exp);
                    end
                end
            end else if ({a_mwr, a_din} !== 9'h000) begin
                errors++;
                $display("FAIL sb_a idle got wr=%b din=%h want wr=0 din=00", a_mwr, a_din);
            end
        end
    end

    always @(negedge clk) begin
        if (sb_on) begin
            b_got = mk(b_gnt, b_maddr, b_mwr, b_mdout, b_din);
            checks++;
            if (b_gnt !== 3'b000) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_b unexpected grant got gnt=%b addr=%h want no grant", b_gnt, b_maddr);
                end else begin
                    b_exp = qb.pop_front();
                    if (b_got !== b_exp) begin
                        errors++;
                        $display("FAIL sb_b txn got=%h want=%h (gnt,addr,wr,dout,din)", b_got, b_exp);
                    end
                end
            end else if ({b_mwr, b_din} !== 9'h000) begin
                errors++;
                $display("FAIL sb_b idle got wr=%b din=%h want wr=0 din=00", b_mwr, b_din);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Requests present during reset must still leave every output at 0.
        a_req = 3'b001; a_wr = 3'b001; a_addr = 24'h0000AA; a_dout = 24'h000055;
        b_req = 3'b100;
        @(negedge clk);
        checks++;
        if ({a_gnt, a_mwr, a_mrd, a_busy, a_maddr, a_din} !== 22'h0) begin
            errors++;
            $display("FAIL reset_a got gnt=%b wr=%b busy=%b addr=%h want all 0", a_gnt, a_mwr, a_busy, a_maddr);
        end
        checks++;
        if ({b_gnt, b_mrd, b_busy, b_maddr} !== 13'h0) begin
            errors++;
            $display("FAIL reset_b got gnt=%b rd=%b busy=%b addr=%h want all 0", b_gnt, b_mrd, b_busy, b_maddr);
        end
        next_cycle();
        rst = 1'b1;
        a_req = 3'b000; a_wr = 3'b000; a_addr = '0; a_dout = '0;
        b_req = 3'b000;
        sb_on = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_busy, b_busy, a_mrd, b_mrd} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle got busy_a=%b busy_b=%b want 0 0", a_busy, b_busy);
        end
        checks++;
        if (mem_a[8'hAA] !== 8'h00) begin
            errors++;
            $display("FAIL reset_nowrite got mem[AA]=%h want 00", mem_a[8'hAA]);
        end
        next_cycle();
    endtask

    task automatic test_single_write();
        a_req = 3'b010; a_wr = 3'b010; a_addr = 24'h00FE00; a_dout = 24'h003C00;
        qa.push_back(mk(3'b010, 8'hFE, 1'b1, 8'h3C, 8'h00));
        @(negedge clk);
        checks++;
        if (a_gnt !== 3'b010) begin
            errors++;
            $display("FAIL single_gnt got=%b want=010", a_gnt);
        end
        checks++;
        if ({a_mwr, a_mrd, a_busy, a_maddr, a_mdout} !== {3'b101, 8'hFE, 8'h3C}) begin
            errors++;
            $display("FAIL single_mem got wr=%b rd=%b busy=%b addr=%h dout=%h want 1 0 1 fe 3c",
                     a_mwr, a_mrd, a_busy, a_maddr, a_mdout);
        end
        next_cycle();
        a_req = 3'b000; a_wr = 3'b000;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got busy=%b want 0", a_busy);
        end
        checks++;
        if (mem_a[8'hFE] !== 8'h3C) begin
            errors++;
            $display("FAIL single_commit got mem[FE]=%h want 3c", mem_a[8'hFE]);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4];
        logic [2:0] g;
`ifdef DBUS_FIXED_PRIO_EN
        seq = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        seq = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        a_req = 3'b011; a_wr = 3'b011; a_addr = 24'h002120; a_dout = 24'h002211;
        for (int k = 0; k < 4; k++) begin
            g = 3'b000;
            g[seq[k]] = 1'b1;
            qa.push_back(mk(g, 8'h20 + {6'b0, seq[k]}, 1'b1, (seq[k] == 2'd0) ? 8'h11 : 8'h22, 8'h00));
        end
        for (int k = 0; k < 4; k++) begin
            g = 3'b000;
            g[seq[k]] = 1'b1;
            @(negedge clk);
            checks++;
            if (a_gnt !== g) begin
                errors++;
                $display("FAIL rr2_cycle%0d got gnt=%b want=%b", k, a_gnt, g);
            end
            next_cycle();
        end
        a_req = 3'b000; a_wr = 3'b000;
    endtask

    task automatic test_rr_three();
        logic [1:0] seq [3];
        logic [2:0] g;
`ifdef DBUS_FIXED_PRIO_EN
        seq = '{2'd0, 2'd0, 2'd0};
`else
        seq = '{2'd2, 2'd0, 2'd1};
`endif
        a_req = 3'b111; a_wr = 3'b111; a_addr = 24'h323130; a_dout = 24'h424140;
        for (int k = 0; k < 3; k++) begin
            g = 3'b000;
            g[seq[k]] = 1'b1;
            qa.push_back(mk(g, 8'h30 + {6'b0, seq[k]}, 1'b1, 8'h40 + {6'b0, seq[k]}, 8'h00));
        end
        for (int k = 0; k < 3; k++) begin
            g = 3'b000;
            g[seq[k]] = 1'b1;
            @(negedge clk);
            checks++;
            if (a_gnt !== g) begin
                errors++;
                $display("FAIL rr3_cycle%0d got gnt=%b want=%b", k, a_gnt, g);
            end
            next_cycle();
        end
        a_req = 3'b000; a_wr = 3'b000; a_addr = '0; a_dout = '0;
    endtask

    task automatic test_back_to_back_stack();
        // Push A1,B2 to SP-1,SP-2 (SP=80), then pop from SP,SP+1 (SP=7E).
        logic [7:0] ad [4];
        logic       wr [4];
        logic [7:0] dt [4];
        logic [7:0] di [4];
        ad = '{8'h7F, 8'h7E, 8'h7E, 8'h7F};
        wr = '{1'b1, 1'b1, 1'b0, 1'b0};
        dt = '{8'hA1, 8'hB2, 8'h00, 8'h00};
        di = '{8'h00, 8'h00, 8'hB2, 8'hA1};
        for (int k = 0; k < 4; k++) begin
            a_req = 3'b010;
            a_wr  = {1'b0, wr[k], 1'b0};
            a_addr = {8'h00, ad[k], 8'h00};
            a_dout = {8'h00, dt[k], 8'h00};
            qa.push_back(mk(3'b010, ad[k], wr[k], dt[k], di[k]));
            @(negedge clk);
            checks++;
            if ({a_gnt, a_din} !== {3'b010, di[k]}) begin
                errors++;
                $display("FAIL stack_op%0d got gnt=%b din=%h want gnt=010 din=%h", k, a_gnt, a_din, di[k]);
            end
            next_cycle();
        end
        a_req = 3'b000; a_wr = 3'b000; a_addr = '0; a_dout = '0;
    endtask

    task automatic test_wait_read();
        logic [4:0] exp_v [5];   // {busy, rd, gnt}
        exp_v = '{5'b00000, 5'b11000, 5'b11000, 5'b11100, 5'b00000};
        b_req = 3'b100; b_wr = 3'b000; b_addr = 24'h100000; b_dout = 24'hEE0000;
        qb.push_back(mk(3'b100, 8'h10, 1'b0, 8'hEE, 8'hA5));
        for (int k = 0; k < 5; k++) begin
            if (k == 4) b_req = 3'b000;
            @(negedge clk);
            checks++;
            if ({b_busy, b_mrd, b_gnt} !== exp_v[k]) begin
                errors++;
                $display("FAIL wait_read_cycle%0d got busy,rd,gnt=%b want=%b", k, {b_busy, b_mrd, b_gnt}, exp_v[k]);
            end
            next_cycle();
        end
        b_addr = '0; b_dout = '0;
    endtask

    task automatic test_abort();
        logic [5:0] exp_v [8];   // {busy, rd, wr, gnt}
        exp_v = '{6'b000000, 6'b100000, 6'b000000, 6'b000000,
                  6'b110000, 6'b110000, 6'b110010, 6'b000000};
        b_req = 3'b011; b_wr = 3'b001; b_addr = 24'h004140; b_dout = 24'h000077;
        qb.push_back(mk(3'b010, 8'h41, 1'b0, 8'h00, 8'h5A));
        for (int k = 0; k < 8; k++) begin
            if (k == 2) b_req = 3'b010;
            if (k == 7) b_req = 3'b000;
            @(negedge clk);
            checks++;
            if (k == 2) begin
                if ({b_mwr, b_gnt} !== exp_v[k][3:0]) begin
                    errors++;
                    $display("FAIL abort_cycle%0d got wr,gnt=%b want=%b", k, {b_mwr, b_gnt}, exp_v[k][3:0]);
                end
            end else if ({b_busy, b_mrd, b_mwr, b_gnt} !== exp_v[k]) begin
                errors++;
                $display("FAIL abort_cycle%0d got busy,rd,wr,gnt=%b want=%b", k, {b_busy, b_mrd, b_mwr, b_gnt}, exp_v[k]);
            end
            next_cycle();
        end
        checks++;
        if (mem_b[8'h40] !== 8'h00) begin
            errors++;
            $display("FAIL abort_nowrite got mem[40]=%h want 00", mem_b[8'h40]);
        end
        b_wr = 3'b000; b_addr = '0; b_dout = '0;
    endtask

    task automatic test_reset_mid_access();
        logic [5:0] exp_v [8];   // {busy, rd, wr, gnt}
        exp_v = '{6'b000000, 6'b100000, 6'b000000, 6'b000000,
                  6'b110000, 6'b110000, 6'b110001, 6'b000000};
        b_req = 3'b101; b_wr = 3'b100; b_addr = 24'h500051; b_dout = 24'h990000;
        qb.push_back(mk(3'b001, 8'h51, 1'b0, 8'h00, 8'h3C));
        for (int k = 0; k < 8; k++) begin
            if (k == 2) rst = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 7) b_req = 3'b000;
            @(negedge clk);
            checks++;
            if (k == 2) begin
                if ({b_gnt, b_din, b_maddr, b_mwr, b_mrd, b_mdout, b_busy} !== 30'h0) begin
                    errors++;
                    $display("FAIL rstmid_zero got gnt=%b din=%h addr=%h wr=%b rd=%b dout=%h busy=%b want all 0",
                             b_gnt, b_din, b_maddr, b_mwr, b_mrd, b_mdout, b_busy);
                end
            end else if ({b_busy, b_mrd, b_mwr, b_gnt} !== exp_v[k]) begin
                errors++;
                $display("FAIL rstmid_cycle%0d got busy,rd,wr,gnt=%b want=%b", k, {b_busy, b_mrd, b_mwr, b_gnt}, exp_v[k]);
            end
            next_cycle();
        end
        checks++;
        if (mem_b[8'h50] !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_nowrite got mem[50]=%h want 00", mem_b[8'h50]);
        end
        b_wr = 3'b000; b_addr = '0; b_dout = '0;
    endtask

    task automatic test_drain();
        next_cycle();
        next_cycle();
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL drain_a got %0d pending grants want 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL drain_b got %0d pending grants want 0", qb.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        sb_on = 1'b0;
        mem_clr = 1'b1;
        a_req = '0; a_wr = '0; a_addr = '0; a_dout = '0;
        b_req = '0; b_wr = '0; b_addr = '0; b_dout = '0;
        next_cycle();
        next_cycle();
        mem_clr = 1'b0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_rr_three();
        test_back_to_back_stack();
        test_wait_read();
        test_abort();
        test_reset_mid_access();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
